prime_sequencer: RTL and testbench



---
 rtl/prime_sequencer.sv | 141 ++++++++++++++
 tb/tb_prime_sequencer.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/prime_sequencer.sv
// Prime sequencer: walks candidates 2..2^WIDTH-1 one per clock and presents
// each prime on a valid/ready output. At the end of the range it either wraps
// to 2 (loop_i=1) or returns to idle with a one-cycle done pulse.
//
// Ports:
//   clk       rising-edge clock
//   rst_n     asynchronous active-low reset
//   start_i   begin a sequence (honoured only when idle)
//   abort_i   synchronous abort back to idle, highest priority
//   loop_i    end-of-range choice: 1 = wrap to 2, 0 = stop with done
//   ready_i   downstream accepts x_out_o this cycle
//   x_out_o   current prime, stable while valid_o=1
//   valid_o   x_out_o holds a prime awaiting acceptance
//   busy_o    sequencer not idle
//   done_o    one-cycle pulse after a non-looping sequence ends
//   count_o   primes accepted since last start, modulo 2^WIDTH
module prime_sequencer #(
  parameter int unsigned WIDTH = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start_i,
  input  logic             abort_i,
  input  logic             loop_i,
  input  logic             ready_i,
  output logic [WIDTH-1:0] x_out_o,
  output logic             valid_o,
  output logic             busy_o,
  output logic             done_o,
  output logic [WIDTH-1:0] count_o
);

  localparam logic [WIDTH-1:0] MaxCand   = {WIDTH{1'b1}};
  localparam logic [WIDTH-1:0] FirstCand = WIDTH'(2);

  typedef enum logic [1:0] {StIdle, StScan, StHold} state_e;

  state_e           state_q;
  logic [WIDTH-1:0] cand_q;
  logic [WIDTH-1:0] x_out_q;
  logic [WIDTH-1:0] count_q;
  logic             valid_q;
  logic             busy_q;
  logic             done_q;
  logic             cand_prime;

  // Trial division over every divisor below n; loop bounds are static.
  function automatic logic is_prime(logic [WIDTH-1:0] n);
    int unsigned nn;
    logic        p;
    nn = 32'(n);
    p  = (nn >= 32'd2);
    for (int unsigned d = 2; d < (32'd1 << WIDTH); d++) begin
      if ((d < nn) && ((nn % d) == 32'd0)) p = 1'b0;
    end
    return p;
  endfunction

  always_comb begin
    cand_prime = is_prime(cand_q);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      cand_q  <= '0;
      x_out_q <= '0;
      count_q <= '0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (abort_i) begin
        // Abort wins over start and over a same-cycle handshake.
        state_q <= StIdle;
        valid_q <= 1'b0;
        busy_q  <= 1'b0;
      end else begin
        unique case (state_q)
          StIdle: begin
            if (start_i) begin
              cand_q  <= FirstCand;
              count_q <= '0;
              state_q <= StScan;
              busy_q  <= 1'b1;
            end
          end
          StScan: begin
            if (cand_prime) begin
              x_out_q <= cand_q;
              valid_q <= 1'b1;
              state_q <= StHold;
            end else if (cand_q == MaxCand) begin
              if (loop_i) begin
                cand_q  <= FirstCand;
              end else begin
                state_q <= StIdle;
                busy_q  <= 1'b0;
                done_q  <= 1'b1;
              end
            end else begin
              cand_q <= cand_q + 1'b1;
            end
          end
          StHold: begin
            if (ready_i) begin
              count_q <= count_q + 1'b1;
              valid_q <= 1'b0;
              if (cand_q == MaxCand) begin
                if (loop_i) begin
                  cand_q  <= FirstCand;
                  state_q <= StScan;
                end else begin
                  state_q <= StIdle;
                  busy_q  <= 1'b0;
                  done_q  <= 1'b1;
                end
              end else begin
                cand_q  <= cand_q + 1'b1;
                state_q <= StScan;
              end
            end
          end
          default: begin
            state_q <= StIdle;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
          end
        endcase
      end
    end
  end

  assign x_out_o = x_out_q;
  assign valid_o = valid_q;
  assign busy_o  = busy_q;
  assign done_o  = done_q;
  assign count_o = count_q;

endmodule

// File: tb/tb_prime_sequencer.sv
// Bench for prime_sequencer: one WIDTH=3 and one WIDTH=4 instance share the
// stimulus; sel picks which one receives start and which one is observed.
// Expected primes and their arrival cycles come from trial division and the
// scan-count timing rule, not from the design's state machine.
module tb_prime_sequencer;

  logic clk = 1'b0;
  logic rst_n;
  logic start;
  logic abort;
  logic lp;
  logic ready;
  logic sel;

  logic [2:0] x3, c3;
  logic       v3, b3, d3;
  logic [3:0] x4, c4;
  logic       v4, b4, d4;

  logic [31:0] o_x, o_valid, o_busy, o_done, o_count;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  prime_sequencer #(.WIDTH(3)) u_w3 (
    .clk     (clk),
    .rst_n   (rst_n),
    .start_i (start & ~sel),
    .abort_i (abort),
    .loop_i  (lp),
    .ready_i (ready),
    .x_out_o (x3),
    .valid_o (v3),
    .busy_o  (b3),
    .done_o  (d3),
    .count_o (c3)
  );

  prime_sequencer #(.WIDTH(4)) u_w4 (
    .clk     (clk),
    .rst_n   (rst_n),
    .start_i (start & sel),
    .abort_i (abort),
    .loop_i  (lp),
    .ready_i (ready),
    .x_out_o (x4),
    .valid_o (v4),
    .busy_o  (b4),
    .done_o  (d4),
    .count_o (c4)
  );

  assign o_x     = sel ? {28'b0, x4} : {29'b0, x3};
  assign o_count = sel ? {28'b0, c4} : {29'b0, c3};
  assign o_valid = {31'b0, sel ? v4 : v3};
  assign o_busy  = {31'b0, sel ? b4 : b3};
  assign o_done  = {31'b0, sel ? d4 : d3};

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s w=%0d t=%0t observed=%0d expected=%0d", tag, sel ? 4 : 3, $time, obs,
             exp);
    end
  endtask

  function automatic bit is_p(int n);
    if (n < 2) return 1'b0;
    for (int d = 2; d < n; d++) if (n % d == 0) return 1'b0;
    return 1'b1;
  endfunction

  function automatic int next_prime(int p, int maxv);
    for (int n = p + 1; n <= maxv; n++) if (is_p(n)) return n;
    return -1;
  endfunction

  // Cycle c is the cycle in which start is driven (c=0). A prime accepted in
  // cycle h is followed by the next prime at cycle h+1+k, k = candidates scanned.
  // mode: 0 ready always 1, 1 random ready and stray starts, 2 stall 5 cycles on 3.
  task automatic run(input bit s, input bit lpv, input int n_acc, input int mode);
    int c, arr, exp_p, cnt, acc, done_cyc, maxv, np, stall;
    bit fin, hold, rdy, via_done;
    sel = s;
    lp = lpv;
    maxv = s ? 15 : 7;
    c = 0; arr = 2; exp_p = 2; cnt = 0; acc = 0; done_cyc = -1; stall = 0;
    fin = 1'b0; via_done = 1'b0;
    while (!fin && c < 400) begin
      hold = (c >= arr);
      if (c == done_cyc) begin
        chk("done_pulse", o_done, 1);
        chk("busy_at_done", o_busy, 0);
        chk("valid_at_done", o_valid, 0);
        chk("count_at_done", o_count, 32'(cnt));
        fin = 1'b1;
        via_done = 1'b1;
        start = 1'b0;
        ready = 1'b0;
      end else begin
        chk("valid", o_valid, 32'(hold));
        chk("done_low", o_done, 0);
        if (c > 0) chk("busy", o_busy, 1);
        if (hold) begin
          chk("x_out", o_x, 32'(exp_p));
          chk("count", o_count, 32'(cnt));
        end
        case (mode)
          0: rdy = 1'b1;
          1: rdy = 1'($urandom_range(0, 1));
          default: begin
            if (hold && exp_p == 3 && stall < 5) begin
              rdy = 1'b0;
              stall++;
            end else begin
              rdy = 1'b1;
            end
          end
        endcase
        ready = rdy;
        start = (c == 0) || (mode == 1 && c > 1 && $urandom_range(0, 3) == 0);
        if (hold && rdy) begin
          acc++;
          cnt = (cnt + 1) % (maxv + 1);
          np = next_prime(exp_p, maxv);
          if (np > 0) begin
            arr = c + 1 + (np - exp_p);
            exp_p = np;
          end else if (lpv) begin
            arr = c + 2 + (maxv - exp_p);
            exp_p = 2;
          end else begin
            done_cyc = c + 1 + (maxv - exp_p);
            arr = 1 << 30;
          end
          if (acc == n_acc) fin = 1'b1;
        end
        @(negedge clk);
        c++;
      end
    end
    start = 1'b0;
    ready = 1'b0;
    if (!fin) begin
      vectors++;
      miscompares++;
      $error("FAIL run_timeout observed=%0d cycles expected=completion", c);
    end else if (via_done) begin
      @(negedge clk);
      chk("done_one_cycle", o_done, 0);
      chk("busy_idle", o_busy, 0);
    end else begin
      chk("count_accum", o_count, 32'(cnt));
    end
  endtask

  task automatic do_abort();
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    chk("abort_busy", o_busy, 0);
    chk("abort_valid", o_valid, 0);
    chk("abort_done", o_done, 0);
  endtask

  initial begin
    rst_n = 1'b0;
    start = 1'b0;
    abort = 1'b0;
    lp    = 1'b0;
    ready = 1'b0;
    sel   = 1'b0;
    repeat (2) @(negedge clk);
    for (int w = 0; w < 2; w++) begin
      sel = 1'(w);
      #1;
      chk("rst_x", o_x, 0);
      chk("rst_valid", o_valid, 0);
      chk("rst_busy", o_busy, 0);
      chk("rst_done", o_done, 0);
      chk("rst_count", o_count, 0);
    end
    sel = 1'b0;
    rst_n = 1'b1;
    @(negedge clk);
    chk("idle_valid", o_valid, 0);
    chk("idle_busy", o_busy, 0);

    run(1'b0, 1'b0, 1000, 0);   // 2,3,5,7 then done
    run(1'b1, 1'b0, 1000, 0);   // 2..13, 14/15 scanned, done with count 6
    run(1'b0, 1'b0, 1000, 2);   // backpressure on 3
    run(1'b0, 1'b1, 6, 0);      // loop: 2,3,5,7,2,3 -> count 6
    do_abort();
    run(1'b0, 1'b1, 25, 1);
    do_abort();
    run(1'b1, 1'b1, 15, 1);
    do_abort();

    // Abort in HOLD with a same-cycle handshake on 5.
    run(1'b0, 1'b0, 2, 0);
    for (int i = 0; i < 10 && o_valid == 0; i++) @(negedge clk);
    chk("pre_abort_valid", o_valid, 1);
    chk("pre_abort_x", o_x, 5);
    ready = 1'b1;
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    ready = 1'b0;
    chk("ab_valid", o_valid, 0);
    chk("ab_busy", o_busy, 0);
    chk("ab_done", o_done, 0);
    chk("ab_count", o_count, 2);
    chk("ab_x_hold", o_x, 5);
    @(negedge clk);
    chk("ab_no_done", o_done, 0);
    run(1'b0, 1'b0, 1000, 0);

    // Asynchronous reset mid-scan with start held high.
    run(1'b0, 1'b0, 3, 0);
    start = 1'b1;
    #2 rst_n = 1'b0;
    #1;
    chk("ar_x", o_x, 0);
    chk("ar_valid", o_valid, 0);
    chk("ar_busy", o_busy, 0);
    chk("ar_done", o_done, 0);
    chk("ar_count", o_count, 0);
    repeat (3) @(negedge clk);
    chk("ar_hold_busy", o_busy, 0);
    #2 rst_n = 1'b1;
    @(negedge clk);
    chk("ar_first_valid", o_valid, 0);
    chk("ar_first_busy", o_busy, 1);
    @(negedge clk);
    chk("ar_valid2", o_valid, 1);
    chk("ar_x2", o_x, 2);
    start = 1'b0;
    do_abort();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
